ball_tracker: RTL and testbench

//  Downstream of ball detection. Takes the once-per-frame ball grid cell (40x30 grid of 16x16 blocks) and its green count.

---
 rtl/ball_tracker.sv | 247 ++++++++++++++++++++++++
 tb/tb_ball_tracker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_tracker.sv
// Ball tracker: filters once-per-frame grid detections into a locked, velocity-annotated track.
// Optional macro BALL_TRACKER_SMOOTH_EN averages near hits with the current track while locked.
module ball_tracker #(
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned MIN_COUNT    = 8,
  parameter int unsigned ACQ_FRAMES   = 3,
  parameter int unsigned COAST_FRAMES = 4,
  parameter int unsigned JUMP_MAX     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_valid_i,
  input  logic [5:0] ball_x_i,
  input  logic [4:0] ball_y_i,
  input  logic [7:0] ball_count_i,
  output logic [5:0] trk_x_o,
  output logic [4:0] trk_y_o,
  output logic [6:0] vel_x_o,
  output logic [5:0] vel_y_o,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic       out_valid_o
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_COAST   = 2'd3
  } state_e;

  localparam logic [5:0]        XMAX_C = 6'(COLS - 1);
  localparam logic [4:0]        YMAX_C = 5'(ROWS - 1);
  localparam logic signed [7:0] XMAX_S = 8'(COLS - 1);
  localparam logic signed [7:0] YMAX_S = 8'(ROWS - 1);

  state_e            state_q, state_d;
  logic              v1_q;
  logic [5:0]        mx_q;
  logic [4:0]        my_q;
  logic [7:0]        mc_q;
  logic [5:0]        cand_x_q, cand_x_d;
  logic [4:0]        cand_y_q, cand_y_d;
  logic [3:0]        acq_q, acq_d;
  logic [3:0]        coast_q, coast_d;
  logic [5:0]        trk_x_q, trk_x_d;
  logic [4:0]        trk_y_q, trk_y_d;
  logic [6:0]        vel_x_q, vel_x_d;
  logic [5:0]        vel_y_q, vel_y_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_s;
  logic              hit_s, near_s;
  logic [5:0]        ref_x_s;
  logic [4:0]        ref_y_s;
  logic signed [6:0] dx_s;
  logic signed [5:0] dy_s;
  logic [6:0]        adx_s;
  logic [5:0]        ady_s;
  logic signed [7:0] px_s, py_s;
  logic [5:0]        pred_x_s;
  logic [4:0]        pred_y_s;
  logic [5:0]        new_x_s;
  logic [4:0]        new_y_s;
  logic signed [6:0] nvx_s, evx_s;
  logic signed [5:0] nvy_s, evy_s;

  // A frame strobe directly after an accepted one is dropped.
  assign accept_s = frame_valid_i & ~v1_q;

  // Input capture stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      mx_q <= 6'd0;
      my_q <= 5'd0;
      mc_q <= 8'd0;
    end else begin
      v1_q <= accept_s;
      if (accept_s) begin
        mx_q <= ball_x_i;
        my_q <= ball_y_i;
        mc_q <= ball_count_i;
      end
    end
  end

  // Hit/near classification, prediction and candidate velocities.
  always_comb begin
    hit_s   = (mc_q >= 8'(MIN_COUNT)) && (mx_q <= XMAX_C) && (my_q <= YMAX_C);
    ref_x_s = (state_q == S_ACQUIRE) ? cand_x_q : trk_x_q;
    ref_y_s = (state_q == S_ACQUIRE) ? cand_y_q : trk_y_q;
    dx_s    = $signed({1'b0, mx_q}) - $signed({1'b0, ref_x_s});
    dy_s    = $signed({1'b0, my_q}) - $signed({1'b0, ref_y_s});
    adx_s   = dx_s[6] ? 7'(-dx_s) : 7'(dx_s);
    ady_s   = dy_s[5] ? 6'(-dy_s) : 6'(dy_s);
    near_s  = hit_s && (adx_s <= 7'(JUMP_MAX)) && (ady_s <= 6'(JUMP_MAX));

    px_s = $signed({2'b00, trk_x_q}) + $signed({vel_x_q[6], vel_x_q});
    py_s = $signed({3'b000, trk_y_q}) + $signed({{2{vel_y_q[5]}}, vel_y_q});
    if (px_s < 8'sd0) begin
      pred_x_s = 6'd0;
    end else if (px_s > XMAX_S) begin
      pred_x_s = XMAX_C;
    end else begin
      pred_x_s = px_s[5:0];
    end
    if (py_s < 8'sd0) begin
      pred_y_s = 5'd0;
    end else if (py_s > YMAX_S) begin
      pred_y_s = YMAX_C;
    end else begin
      pred_y_s = py_s[4:0];
    end

`ifdef BALL_TRACKER_SMOOTH_EN
    new_x_s = 6'((7'(trk_x_q) + 7'(mx_q) + 7'd1) >> 1);
    new_y_s = 5'((6'(trk_y_q) + 6'(my_q) + 6'd1) >> 1);
`else
    new_x_s = mx_q;
    new_y_s = my_q;
`endif
    nvx_s = $signed({1'b0, new_x_s}) - $signed({1'b0, trk_x_q});
    nvy_s = $signed({1'b0, new_y_s}) - $signed({1'b0, trk_y_q});
    evx_s = $signed({1'b0, mx_q}) - $signed({1'b0, cand_x_q});
    evy_s = $signed({1'b0, my_q}) - $signed({1'b0, cand_y_q});
  end

  // Tracker next-state and output update, evaluated once per accepted frame.
  always_comb begin
    state_d     = state_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    acq_d       = acq_q;
    coast_d     = coast_q;
    trk_x_d     = trk_x_q;
    trk_y_d     = trk_y_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    out_valid_d = 1'b0;
    if (v1_q) begin
      out_valid_d = 1'b1;
      case (state_q)
        S_SEARCH: begin
          if (hit_s) begin
            state_d  = S_ACQUIRE;
            cand_x_d = mx_q;
            cand_y_d = my_q;
            acq_d    = 4'd1;
          end else begin
            state_d = S_SEARCH;
          end
        end
        S_ACQUIRE: begin
          if (near_s) begin
            cand_x_d = mx_q;
            cand_y_d = my_q;
            if (acq_q + 4'd1 == 4'(ACQ_FRAMES)) begin
              state_d = S_TRACK;
              acq_d   = 4'd0;
              trk_x_d = mx_q;
              trk_y_d = my_q;
              vel_x_d = evx_s;
              vel_y_d = evy_s;
            end else begin
              acq_d = acq_q + 4'd1;
            end
          end else if (hit_s) begin
            cand_x_d = mx_q;
            cand_y_d = my_q;
            acq_d    = 4'd1;
          end else begin
            state_d = S_SEARCH;
            acq_d   = 4'd0;
          end
        end
        S_TRACK, S_COAST: begin
          if (near_s) begin
            state_d = S_TRACK;
            coast_d = 4'd0;
            trk_x_d = new_x_s;
            trk_y_d = new_y_s;
            vel_x_d = nvx_s;
            vel_y_d = nvy_s;
          end else if (state_q == S_TRACK) begin
            state_d = S_COAST;
            coast_d = 4'd1;
            trk_x_d = pred_x_s;
            trk_y_d = pred_y_s;
          end else if (coast_q + 4'd1 == 4'(COAST_FRAMES)) begin
            // Lock lost: position freezes at the last prediction.
            state_d = S_SEARCH;
            coast_d = 4'd0;
            vel_x_d = 7'd0;
            vel_y_d = 6'd0;
          end else begin
            coast_d = coast_q + 4'd1;
            trk_x_d = pred_x_s;
            trk_y_d = pred_y_s;
          end
        end
        default: begin
          state_d = S_SEARCH;
        end
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Tracker state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_SEARCH;
      cand_x_q    <= 6'd0;
      cand_y_q    <= 5'd0;
      acq_q       <= 4'd0;
      coast_q     <= 4'd0;
      trk_x_q     <= 6'd0;
      trk_y_q     <= 5'd0;
      vel_x_q     <= 7'd0;
      vel_y_q     <= 6'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      acq_q       <= acq_d;
      coast_q     <= coast_d;
      trk_x_q     <= trk_x_d;
      trk_y_q     <= trk_y_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign trk_x_o     = trk_x_q;
  assign trk_y_o     = trk_y_q;
  assign vel_x_o     = vel_x_q;
  assign vel_y_o     = vel_y_q;
  assign out_valid_o = out_valid_q;
  assign state_o     = state_q;
  assign locked_o    = (state_q == S_TRACK) || (state_q == S_COAST);

endmodule

// File: tb/tb_ball_tracker.sv
// Self-checking bench for ball_tracker: directed scenarios plus a randomized run
// compared against a frame-level behavioural model.
module tb_ball_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fv;
  logic [5:0] bx;
  logic [4:0] by;
  logic [7:0] bc;
  logic [5:0] trk_x;
  logic [4:0] trk_y;
  logic [6:0] vel_x;
  logic [5:0] vel_y;
  logic       locked;
  logic [1:0] state;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model state (plain integers, one update per frame).
  int m_state, m_tx, m_ty, m_vx, m_vy, m_cx, m_cy, m_acq, m_coast;

  ball_tracker dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_valid_i(fv),
    .ball_x_i     (bx),
    .ball_y_i     (by),
    .ball_count_i (bc),
    .trk_x_o      (trk_x),
    .trk_y_o      (trk_y),
    .vel_x_o      (vel_x),
    .vel_y_o      (vel_y),
    .locked_o     (locked),
    .state_o      (state),
    .out_valid_o  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_tx = 0; m_ty = 0; m_vx = 0; m_vy = 0;
    m_cx = 0; m_cy = 0; m_acq = 0; m_coast = 0;
  endtask

  task automatic model_frame(input int x, input int y, input int c);
    bit hit, near;
    int rx, ry, nx, ny;
    hit  = (c >= 8) && (x < 40) && (y < 30);
    rx   = (m_state == 1) ? m_cx : m_tx;
    ry   = (m_state == 1) ? m_cy : m_ty;
    near = hit && absi(x - rx) <= 4 && absi(y - ry) <= 4;
    if (m_state == 0) begin
      if (hit) begin m_state = 1; m_cx = x; m_cy = y; m_acq = 1; end
    end else if (m_state == 1) begin
      if (near) begin
        m_acq++;
        if (m_acq == 3) begin
          m_state = 2; m_vx = x - m_cx; m_vy = y - m_cy; m_tx = x; m_ty = y;
        end
        m_cx = x; m_cy = y;
      end else if (hit) begin
        m_cx = x; m_cy = y; m_acq = 1;
      end else begin
        m_state = 0;
      end
    end else if (near) begin
`ifdef BALL_TRACKER_SMOOTH_EN
      nx = (m_tx + x + 1) / 2;
      ny = (m_ty + y + 1) / 2;
`else
      nx = x;
      ny = y;
`endif
      m_vx = nx - m_tx; m_vy = ny - m_ty; m_tx = nx; m_ty = ny;
      m_state = 2; m_coast = 0;
    end else if (m_state == 2) begin
      m_state = 3; m_coast = 1;
      m_tx = clampi(m_tx + m_vx, 39); m_ty = clampi(m_ty + m_vy, 29);
    end else begin
      m_coast++;
      if (m_coast == 4) begin
        m_state = 0; m_vx = 0; m_vy = 0;
      end else begin
        m_tx = clampi(m_tx + m_vx, 39); m_ty = clampi(m_ty + m_vy, 29);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    fv = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one frame and returns the cycle count until OUT_VALID (-1 on timeout).
  task automatic send_frame(input int x, input int y, input int c, output int lat);
    @(posedge clk); #1;
    fv = 1'b1; bx = 6'(x); by = 5'(y); bc = 8'(c);
    @(posedge clk); #1;
    fv = 1'b0;
    lat = -1;
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    model_frame(x, y, c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fv = 1'b0; bx = 6'd0; by = 5'd0; bc = 8'd0;
    #12;
    checks++;
    if ({state, locked, out_valid, trk_x, trk_y, vel_x, vel_y} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d trk=%0d/%0d vel=%0d/%0d ov=%0d, expected all 0",
               state, trk_x, trk_y, vel_x, vel_y, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_acquire();
    int lat;
    int xs[3] = '{10, 11, 12};
    int exp_st[3] = '{1, 1, 2};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame(xs[i], 10, 20, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL acq_latency[%0d]: got %0d expected 2", i, lat); end
      checks++;
      if (state !== 2'(exp_st[i])) begin errors++; $display("FAIL acq_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
    end
    checks++;
    if (trk_x !== 6'd12 || vel_x !== 7'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL acq_lock: got trk_x=%0d vel_x=%0d locked=%0d expected 12 1 1", trk_x, vel_x, locked);
    end
  endtask

  task automatic test_coast();
    int lat;
    int exp_x[4] = '{13, 14, 15, 15};
    int exp_st[4] = '{3, 3, 3, 0};
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 0, 0, lat);
      checks++;
      if (trk_x !== 6'(exp_x[i]) || state !== 2'(exp_st[i])) begin
        errors++;
        $display("FAIL coast[%0d]: got trk_x=%0d state=%0d expected %0d %0d", i, trk_x, state, exp_x[i], exp_st[i]);
      end
    end
    checks++;
    if (vel_x !== 7'd0 || locked !== 1'b0 || trk_y !== 5'd10) begin
      errors++;
      $display("FAIL coast_drop: got vel_x=%0d locked=%0d trk_y=%0d expected 0 0 10", vel_x, locked, trk_y);
    end
  endtask

  task automatic test_weak();
    int lat;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame(5, 5, 7, lat);
      checks++;
      if (lat !== 2 || state !== 2'd0 || {trk_x, trk_y, vel_x, vel_y} !== 24'd0) begin
        errors++;
        $display("FAIL weak[%0d]: got lat=%0d state=%0d trk_x=%0d vel_x=%0d expected 2 0 0 0", i, lat, state, trk_x, vel_x);
      end
    end
  endtask

  task automatic test_clamp();
    int lat;
    apply_reset();
    send_frame(34, 5, 50, lat);
    send_frame(36, 5, 50, lat);
    send_frame(38, 5, 50, lat);
    checks++;
    if (trk_x !== 6'd38 || vel_x !== 7'd2) begin
      errors++; $display("FAIL clamp_lock: got trk_x=%0d vel_x=%0d expected 38 2", trk_x, vel_x);
    end
    send_frame(0, 0, 0, lat);
    checks++;
    if (trk_x !== 6'd39 || state !== 2'd3) begin
      errors++; $display("FAIL clamp_edge: got trk_x=%0d state=%0d expected 39 3", trk_x, state);
    end
  endtask

  task automatic test_smooth();
    int lat;
    apply_reset();
    send_frame(10, 10, 20, lat);
    send_frame(11, 10, 20, lat);
    send_frame(12, 10, 20, lat);
    send_frame(16, 10, 20, lat);
    checks++;
`ifdef BALL_TRACKER_SMOOTH_EN
    if (trk_x !== 6'd14 || vel_x !== 7'd2 || state !== 2'd2) begin
      errors++; $display("FAIL smooth: got trk_x=%0d vel_x=%0d state=%0d expected 14 2 2", trk_x, vel_x, state);
    end
`else
    if (trk_x !== 6'd16 || vel_x !== 7'd4 || state !== 2'd2) begin
      errors++; $display("FAIL smooth: got trk_x=%0d vel_x=%0d state=%0d expected 16 4 2", trk_x, vel_x, state);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int pulses, lat;
    apply_reset();
    @(posedge clk); #1;
    fv = 1'b1; bx = 6'd20; by = 5'd20; bc = 8'd50;
    @(posedge clk); #1;
    bx = 6'd5; by = 5'd5;
    @(posedge clk); #1;
    pulses = out_valid ? 1 : 0;
    fv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    model_frame(20, 20, 50);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    send_frame(21, 20, 50, lat);
    send_frame(22, 20, 50, lat);
    checks++;
    if (state !== 2'd2 || trk_x !== 6'd22 || vel_x !== 7'd1) begin
      errors++; $display("FAIL b2b_second_ignored: got state=%0d trk_x=%0d vel_x=%0d expected 2 22 1", state, trk_x, vel_x);
    end
  endtask

  task automatic test_random();
    int lat, r, x, y, c, px, py, vx, vy, ovx, ovy;
    apply_reset();
    px = 20; py = 15; vx = 2; vy = 1;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        if (px + vx < 0 || px + vx > 39) vx = -vx;
        if (py + vy < 0 || py + vy > 29) vy = -vy;
        px += vx; py += vy;
        if ($urandom_range(0, 9) == 0) begin
          vx = int'($urandom_range(0, 6)) - 3;
          vy = int'($urandom_range(0, 6)) - 3;
        end
        x = px; y = py; c = int'($urandom_range(8, 255));
      end else if (r < 75) begin
        x = px; y = py; c = int'($urandom_range(0, 7));
      end else if (r < 85) begin
        x = int'($urandom_range(0, 39)); y = int'($urandom_range(0, 29)); c = int'($urandom_range(8, 255));
      end else if (r < 92) begin
        x = int'($urandom_range(40, 63)); y = py; c = 200;
      end else begin
        x = px; y = int'($urandom_range(30, 31)); c = 200;
      end
      send_frame(x, y, c, lat);
      ovx = $signed(vel_x);
      ovy = $signed(vel_y);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected 2", n, lat); end
      checks++;
      if (int'(state) !== m_state || locked !== (m_state >= 2)) begin
        errors++; $display("FAIL rnd_state[%0d]: got %0d locked=%0d expected %0d", n, state, locked, m_state);
      end
      checks++;
      if (int'(trk_x) !== m_tx || int'(trk_y) !== m_ty) begin
        errors++; $display("FAIL rnd_trk[%0d]: got %0d,%0d expected %0d,%0d", n, trk_x, trk_y, m_tx, m_ty);
      end
      checks++;
      if (ovx !== m_vx || ovy !== m_vy) begin
        errors++; $display("FAIL rnd_vel[%0d]: got %0d,%0d expected %0d,%0d", n, ovx, ovy, m_vx, m_vy);
      end
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    send_frame(10, 10, 20, lat);
    send_frame(11, 10, 20, lat);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, locked, out_valid, trk_x, trk_y, vel_x, vel_y} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: got state=%0d locked=%0d trk_x=%0d vel_x=%0d expected all 0", state, locked, trk_x, vel_x);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_coast();
    test_weak();
    test_clamp();
    test_smooth();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
